cpu_axi_bridge: RTL
===================

CPU_AXI_BRIDGE -- requirements
Module: cpu_axi_bridge

Interface
REQ-001 The block SHALL have parameter ID_INST, default 4'd0, which is the AXI ID used for instruction reads.
REQ-002 The block SHALL have parameter ID_DATA, default 4'd1, which is the AXI ID used for data reads and writes.
REQ-003 Port clk: input, 1 bit; the single clock, all state rising-edge.
REQ-004 Port rst: input, 1 bit; the reset is asynchronous and active-low (0 = reset).
REQ-005 Instruction port: inst_req in 1, inst_addr in 32, inst_addr_ok out 1, inst_data_ok out 1, inst_rdata out 32.
REQ-006 Data port: data_req in 1, data_wr in 1 (1 = write), data_wstrb in 4, data_addr in 32, data_wdata in 32.
REQ-007 Data port outputs: data_addr_ok out 1, data_data_ok out 1, data_rdata out 32.
REQ-008 AR channel: arid out 4, araddr out 32, arvalid out 1, arready in 1.
REQ-009 R channel: rdata in 32, rvalid in 1, rready out 1.
REQ-010 AW/W channels: awid out 4, awaddr out 32, awvalid out 1, awready in 1, wdata out 32, wstrb out 4, wvalid out 1, wready in 1.
REQ-011 B channel: bvalid in 1, bready out 1.
REQ-012 Transfers SHALL always be single-beat, 4-byte, INCR; the remaining AXI fields (len=0, size=2, burst=1, wlast=1, wid=awid) SHALL be tied off outside this block.

Function
REQ-013 The block SHALL hold exactly one outstanding transaction, sequenced by the FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
REQ-014 In IDLE with data_req=1, the block SHALL assert data_addr_ok combinationally that cycle and latch addr/wr/wstrb/wdata with source=DATA.
REQ-015 In IDLE with inst_req=1 and data_req=0, the block SHALL assert inst_addr_ok and latch with source=INST; when both requests are present, data wins and inst_addr_ok=0.
REQ-016 addr_ok SHALL never be asserted outside IDLE, and a request is consumed only on the cycle req & addr_ok.
REQ-017 Read accept SHALL go IDLE->RD_ADDR; arvalid=1 with latched araddr, and arid = ID_DATA or ID_INST by source.
REQ-018 In RD_ADDR, on arvalid & arready the block SHALL drop arvalid next cycle and go to RD_DATA; arvalid/araddr SHALL be stable while waiting.
REQ-019 In RD_DATA, rready SHALL be 1; on rvalid & rready, rdata is registered into the source's rdata register, that source's data_ok pulses 1 for exactly the next cycle, and the FSM goes to IDLE.
REQ-020 Return routing SHALL use the latched source; rid is ignored.
REQ-021 Write accept SHALL go IDLE->WR_ADDR, raising awvalid and wvalid together with latched addr, wdata and wstrb.
REQ-022 In WR_ADDR, awvalid and wvalid SHALL each clear independently on their own handshake; when both have completed (same or different cycles), the FSM SHALL go to WR_RESP.
REQ-023 In WR_RESP, bready SHALL be 1; on bvalid, data_data_ok pulses the next cycle and the FSM goes to IDLE; bresp is ignored.
REQ-024 rready SHALL be 0 outside RD_DATA and bready SHALL be 0 outside WR_RESP.
REQ-025 The data_ok pulse cycle SHALL coincide with IDLE, so a new request may be accepted in that same cycle (back-to-back).
REQ-026 Best-case read latency SHALL be: accept at C0, arvalid at C1, with arready and rvalid at C1/C2 giving data_ok at C3.
REQ-027 inst_rdata/data_rdata SHALL hold their last value until the next return to the same port.

Reset
REQ-028 While rst=0, the FSM SHALL be IDLE, all valid, ready, addr_ok and data_ok outputs 0, and the latched addr/data/rdata registers 0.
REQ-029 Reset assertion mid-transaction SHALL drop arvalid/awvalid/wvalid immediately (asynchronously), abandon the transaction, and produce no data_ok.
REQ-030 After rst deasserts, the first request SHALL be acceptable on the first clock edge.

Verification
REQ-031 Inst read 0xBFC00000, arready=1 immediately, rvalid at next cycle with rdata 0x3C080001 -> arid=0, one-cycle inst_data_ok, inst_rdata=0x3C080001.
REQ-032 inst_req and data_req (read 0x80001000) in the same cycle -> data_addr_ok=1, inst_addr_ok=0; data completes first, then inst is accepted in the data_ok cycle.
REQ-033 Data write 0x80002004, wstrb 4'b0011, wdata 0x12345678; awready at C2 and wready at C4 -> awvalid clears after C2, wvalid after C4, bready only afterwards; on bvalid, one data_data_ok pulse.
REQ-034 arready held 0 for 5 cycles -> arvalid/araddr/arid stable throughout, rready=0, no addr_ok.
REQ-035 rst pulled low while in RD_DATA -> all outputs 0 asynchronously; after release, a new inst read completes normally with no stale data_ok.

Source files
------------

// File: rtl/cpu_axi_bridge_if.sv
// Signal bundle between the CPU-side SRAM-like ports and the AXI read/write channels.
// The master modport is the bridge's view; slave is the CPU plus memory side.
interface cpu_axi_bridge_if;
  // Instruction port
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  // Data port
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  // AXI read address / data
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  // AXI write address / data / response
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arvalid,
    input  arready,
    input  rdata, rvalid,
    output rready,
    output awid, awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arvalid,
    output arready,
    output rdata, rvalid,
    input  rready,
    input  awid, awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU instruction/data request ports onto single-beat AXI transfers,
// one transaction in flight; data requests take priority over instruction fetches.
module cpu_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input logic             clk,
  input logic             rst,
  cpu_axi_bridge_if.master bus
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_t;

  typedef struct packed {
    src_t              src;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state;
  req_t              req_q;
  req_t              req_next_c;
  logic              accept_data_c;
  logic              accept_inst_c;
  logic              aw_done_c;
  logic              w_done_c;

  logic              arvalid_q;
  logic              rready_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              inst_data_ok_q;
  logic              data_data_ok_q;
  logic [DATA_W-1:0] inst_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;

  // Acceptance is only possible in IDLE and never while reset is held.
  assign accept_data_c = rst && (state == IDLE) && bus.data_req;
  assign accept_inst_c = rst && (state == IDLE) && bus.inst_req && !bus.data_req;

  // Request payload captured on acceptance; instruction fetches carry no write data.
  always_comb begin
    req_next_c = '0;
    if (bus.data_req) begin
      req_next_c.src   = SRC_DATA;
      req_next_c.wstrb = bus.data_wr ? bus.data_wstrb : STRB_W'(0);
      req_next_c.addr  = bus.data_addr;
      req_next_c.wdata = bus.data_wr ? bus.data_wdata : DATA_W'(0);
    end else begin
      req_next_c.src   = SRC_INST;
      req_next_c.addr  = bus.inst_addr;
    end
  end

  // A write channel counts as done once its valid is already gone or handshakes now.
  assign aw_done_c = !awvalid_q || bus.awready;
  assign w_done_c  = !wvalid_q  || bus.wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      req_q          <= '0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
    end else begin
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_data_c || accept_inst_c) begin
            req_q <= req_next_c;
            if (accept_data_c && bus.data_wr) begin
              state     <= WR_ADDR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state     <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.rvalid) begin
            rready_q <= 1'b0;
            state    <= IDLE;
            // Route by the latched source; the AXI read ID is not consulted.
            if (req_q.src == SRC_DATA) begin
              data_rdata_q   <= bus.rdata;
              data_data_ok_q <= 1'b1;
            end else begin
              inst_rdata_q   <= bus.rdata;
              inst_data_ok_q <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (bus.awready) awvalid_q <= 1'b0;
          if (bus.wready)  wvalid_q  <= 1'b0;
          if (aw_done_c && w_done_c) begin
            bready_q <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.bvalid) begin
            bready_q       <= 1'b0;
            data_data_ok_q <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.inst_addr_ok = accept_inst_c;
  assign bus.data_addr_ok = accept_data_c;
  assign bus.inst_data_ok = inst_data_ok_q;
  assign bus.data_data_ok = data_data_ok_q;
  assign bus.inst_rdata   = inst_rdata_q;
  assign bus.data_rdata   = data_rdata_q;

  assign bus.arid    = (req_q.src == SRC_DATA) ? ID_W'(ID_DATA) : ID_W'(ID_INST);
  assign bus.araddr  = req_q.addr;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

  assign bus.awid    = ID_W'(ID_DATA);
  assign bus.awaddr  = req_q.addr;
  assign bus.awvalid = awvalid_q;
  assign bus.wdata   = req_q.wdata;
  assign bus.wstrb   = req_q.wstrb;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;

endmodule
